// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the iterative RV32M multiply/divide unit.
//   muldiv_op_e    : funct3 operation codes
//   muldiv_state_e : control states (IDLE, CALC, DONE)
//   is_signed_op   : rs1 operand is interpreted as signed
//   rs2_signed_op  : rs2 operand is interpreted as signed
//   is_div_op      : operation belongs to the divide group
//   is_rem_op      : operation returns the remainder
package muldiv_pkg;

   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } muldiv_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      DONE = 2'b10
   } muldiv_state_e;

   // MUL only keeps the low half, which is identical for signed and unsigned.
   function automatic logic is_signed_op(input muldiv_op_e op);
      return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
   endfunction

   function automatic logic rs2_signed_op(input muldiv_op_e op);
      return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
   endfunction

   function automatic logic is_div_op(input muldiv_op_e op);
      return op[2];
   endfunction

   function automatic logic is_rem_op(input muldiv_op_e op);
      return op[2] & op[1];
   endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the core and the multiply/divide unit.
//   start, op, data1, data2 : request from the core (master)
//   ready, valid, Result    : status and result from the unit (slave)
interface muldiv_if
   import muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = 32
);

   logic             start;
   muldiv_op_e       op;
   logic [WIDTH-1:0] data1;
   logic [WIDTH-1:0] data2;
   logic             ready;
   logic             valid;
   logic [WIDTH-1:0] Result;

   modport master (
      output start, op, data1, data2,
      input  ready, valid, Result
   );

   modport slave (
      input  start, op, data1, data2,
      output ready, valid, Result
   );

endinterface

// File: rtl/muldiv_special_detect.sv
// Combinational detection of the RV32M special cases and their fixed results.
//   op_i, data1_i, data2_i : raw request fields
//   div_by_zero_o          : divide-group op with data2 == 0
//   sgn_ovf_o              : DIV/REM of the most negative value by -1
//   zero_operand_o         : multiply-group op with a zero operand
//   special_res_o          : result that overrides the datapath when any flag is set
module muldiv_special_detect
   import muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  muldiv_op_e       op_i,
   input  logic [WIDTH-1:0] data1_i,
   input  logic [WIDTH-1:0] data2_i,
   output logic             div_by_zero_o,
   output logic             sgn_ovf_o,
   output logic             zero_operand_o,
   output logic [WIDTH-1:0] special_res_o
);

   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

   // Flag decode and fixed-result selection
   always_comb begin
      div_by_zero_o  = is_div_op(op_i) && (data2_i == '0);
      sgn_ovf_o      = ((op_i == OP_DIV) || (op_i == OP_REM)) &&
                       (data1_i == MIN_VAL) && (data2_i == '1);
      zero_operand_o = !is_div_op(op_i) && ((data1_i == '0) || (data2_i == '0));
      special_res_o  = '0;
      if (div_by_zero_o) begin
         special_res_o = is_rem_op(op_i) ? data1_i : '1;
      end else if (sgn_ovf_o) begin
         special_res_o = (op_i == OP_DIV) ? data1_i : '0;
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit (radix-2 shift-add / restoring divide).
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset, aborts any operation in flight
//   bus   : muldiv_if slave (start/op/data1/data2 in; ready/valid/Result out)
// Timing: a request accepted on edge E raises valid for one cycle after edge
// E+WIDTH+1; Result holds until the next accepted request.
// Optional feature macro MULDIV_EARLY_OUT_EN: special cases, zero-operand
// multiplies and divides with |data1| < |data2| finish one edge after accept.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input logic     clk,
   input logic     rst,
   muldiv_if.slave bus
);

   localparam int unsigned      CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   muldiv_state_e      state_q;
   muldiv_op_e         op_q;
   logic               s1_q, s2_q;
   logic [WIDTH-1:0]   b_q;
   logic [WIDTH-1:0]   hi_q, lo_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               fin_q;
   logic               spec_q;
   logic [WIDTH-1:0]   spec_res_q;
   logic               ready_q, valid_q;
   logic [WIDTH-1:0]   result_q;

   muldiv_op_e         op_in;
   logic               s1_in, s2_in;
   logic [WIDTH-1:0]   mag1_in, mag2_in;
   logic               dbz, ovf, zop;
   logic [WIDTH-1:0]   spec_res_c;
   logic               spec_in, skip_in;
   logic [WIDTH-1:0]   spec_res_in;

   logic [WIDTH:0]     add_sum, r_shift, diff;
   logic [WIDTH-1:0]   hi_d, lo_d;
   logic [2*WIDTH-1:0] prod, prod_f;
   logic [WIDTH-1:0]   quot_f, rem_f, dp_res, final_res;

   muldiv_special_detect #(.WIDTH(WIDTH)) u_detect (
      .op_i           (bus.op),
      .data1_i        (bus.data1),
      .data2_i        (bus.data2),
      .div_by_zero_o  (dbz),
      .sgn_ovf_o      (ovf),
      .zero_operand_o (zop),
      .special_res_o  (spec_res_c)
   );

   // Request decode: signs, magnitudes and the override decision
   always_comb begin
      op_in       = bus.op;
      s1_in       = is_signed_op(op_in) & bus.data1[WIDTH-1];
      s2_in       = rs2_signed_op(op_in) & bus.data2[WIDTH-1];
      mag1_in     = s1_in ? -bus.data1 : bus.data1;
      mag2_in     = s2_in ? -bus.data2 : bus.data2;
      spec_in     = dbz | ovf | zop;
      spec_res_in = spec_res_c;
`ifdef MULDIV_EARLY_OUT_EN
      skip_in = spec_in;
      // Divisor larger than dividend: quotient 0, remainder is data1 as given
      if (is_div_op(op_in) && !dbz && !ovf && (mag1_in < mag2_in)) begin
         skip_in     = 1'b1;
         spec_in     = 1'b1;
         spec_res_in = is_rem_op(op_in) ? bus.data1 : '0;
      end
`else
      skip_in = 1'b0;
`endif
   end

   // One radix-2 iteration; hi/lo form the accumulator or remainder/quotient pair
   always_comb begin
      add_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
      r_shift = {hi_q, lo_q[WIDTH-1]};
      diff    = r_shift - {1'b0, b_q};
      if (is_div_op(op_q)) begin
         // A set diff MSB means the trial subtraction borrowed: restore
         hi_d = diff[WIDTH] ? r_shift[WIDTH-1:0] : diff[WIDTH-1:0];
         lo_d = {lo_q[WIDTH-2:0], ~diff[WIDTH]};
      end else begin
         hi_d = add_sum[WIDTH:1];
         lo_d = {add_sum[0], lo_q[WIDTH-1:1]};
      end
   end

   // Sign fix-up and result selection
   always_comb begin
      prod   = {hi_q, lo_q};
      prod_f = (s1_q ^ s2_q) ? -prod : prod;
      quot_f = (s1_q ^ s2_q) ? -lo_q : lo_q;
      rem_f  = s1_q ? -hi_q : hi_q;
      case (op_q)
         OP_MUL:                       dp_res = prod_f[WIDTH-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: dp_res = prod_f[2*WIDTH-1:WIDTH];
         OP_DIV, OP_DIVU:              dp_res = quot_f;
         default:                      dp_res = rem_f;
      endcase
      final_res = spec_q ? spec_res_q : dp_res;
   end

   // Control FSM and datapath registers. CALC spends WIDTH cycles iterating
   // (counter WIDTH-1 down to 0) and one more cycle on the sign fix-up.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         op_q       <= OP_MUL;
         s1_q       <= 1'b0;
         s2_q       <= 1'b0;
         b_q        <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
         cnt_q      <= '0;
         fin_q      <= 1'b0;
         spec_q     <= 1'b0;
         spec_res_q <= '0;
         ready_q    <= 1'b1;
         valid_q    <= 1'b0;
         result_q   <= '0;
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.start && ready_q) begin
                  op_q       <= op_in;
                  s1_q       <= s1_in;
                  s2_q       <= s2_in;
                  spec_q     <= spec_in;
                  spec_res_q <= spec_res_in;
                  hi_q       <= '0;
                  lo_q       <= is_div_op(op_in) ? mag1_in : mag2_in;
                  b_q        <= is_div_op(op_in) ? mag2_in : mag1_in;
                  cnt_q      <= CNT_LAST;
                  fin_q      <= skip_in;
                  ready_q    <= 1'b0;
                  state_q    <= CALC;
               end
            end
            CALC: begin
               if (fin_q) begin
                  result_q <= final_res;
                  valid_q  <= 1'b1;
                  fin_q    <= 1'b0;
                  state_q  <= DONE;
               end else begin
                  hi_q <= hi_d;
                  lo_q <= lo_d;
                  if (cnt_q == '0) begin
                     fin_q <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q - CNT_W'(1);
                  end
               end
            end
            DONE: begin
               ready_q <= 1'b1;
               state_q <= IDLE;
            end
            default: begin
               ready_q <= 1'b1;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.ready  = ready_q;
   assign bus.valid  = valid_q;
   assign bus.Result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (WIDTH=32): directed table, handshake
// corner sequences and randomized operations against a 64-bit arithmetic model.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   localparam int unsigned W = 32;
`ifdef MULDIV_EARLY_OUT_EN
   localparam bit EARLY_EN = 1'b1;
`else
   localparam bit EARLY_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;

   muldiv_if #(.WIDTH(W)) bus ();

   muldiv_unit #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      muldiv_op_e  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      string       name;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // RV32M reference using wide arithmetic
   function automatic logic [31:0] ref_model(muldiv_op_e op, logic [31:0] a, logic [31:0] b);
      logic signed [63:0] sp;
      logic [63:0]        up;
      logic signed [31:0] sa, sb;
      logic               ovf;
      logic [31:0]        r;
      sa  = a;
      sb  = b;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (op)
         OP_MUL:    begin up = {32'b0, a} * {32'b0, b}; r = up[31:0]; end
         OP_MULH:   begin sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); r = sp[63:32]; end
         OP_MULHSU: begin sp = $signed({{32{a[31]}}, a}) * $signed({32'b0, b}); r = sp[63:32]; end
         OP_MULHU:  begin up = {32'b0, a} * {32'b0, b}; r = up[63:32]; end
         OP_DIV:    r = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
         OP_DIVU:   r = (b == 0) ? 32'hFFFF_FFFF : a / b;
         OP_REM:    r = (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
         default:   r = (b == 0) ? a : a % b;
      endcase
      return r;
   endfunction

   // Edges from accept to the edge that raises valid
   function automatic int exp_lat(muldiv_op_e op, logic [31:0] a, logic [31:0] b);
      longint ma, mb;
      bit     sgn, early;
      sgn = (op == OP_DIV) || (op == OP_REM);
      ma  = (sgn && a[31]) ? -longint'($signed(a)) : longint'(a);
      mb  = (sgn && b[31]) ? -longint'($signed(b)) : longint'(b);
      if (op >= OP_DIV)
         early = (b == 0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) || (ma < mb);
      else
         early = (a == 0) || (b == 0);
      return (EARLY_EN && early) ? 1 : W + 1;
   endfunction

   task automatic wait_ready(input string name);
      int guard = 0;
      while (!bus.ready && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      chk({name, " ready_wait"}, 32'(bus.ready), 32'd1);
   endtask

   task automatic run_op(input muldiv_op_e op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat_exp, input string name);
      int lat;
      bit busy_ready;
      wait_ready(name);
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = op;
      bus.data1 = a;
      bus.data2 = b;
      @(posedge clk); #1;
      bus.start  = 1'b0;
      busy_ready = bus.ready;
      lat        = 0;
      for (int i = 1; i <= 100; i++) begin
         @(posedge clk); #1;
         busy_ready |= bus.ready;
         if (bus.valid) begin
            lat = i;
            break;
         end
      end
      chk({name, " result"}, bus.Result, exp);
      chk({name, " latency"}, 32'(lat), 32'(lat_exp));
      chk({name, " ready_low"}, 32'(busy_ready), 32'd0);
      @(posedge clk); #1;
      chk({name, " valid_once/ready"}, {30'b0, bus.valid, bus.ready}, 32'b01);
      chk({name, " hold"}, bus.Result, exp);
   endtask

   initial begin
      int lat, vcount;
      muldiv_op_e  rop;
      logic [31:0] ra, rb;

      bus.start = 1'b0;
      bus.op    = OP_MUL;
      bus.data1 = '0;
      bus.data2 = '0;
      rst       = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset ready", 32'(bus.ready), 32'd1);
      chk("reset valid", 32'(bus.valid), 32'd0);
      chk("reset Result", bus.Result, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      vecs.push_back('{OP_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7xm3"});
      vecs.push_back('{OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh_min"});
      vecs.push_back('{OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_max"});
      vecs.push_back('{OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_m1"});
      vecs.push_back('{OP_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, "div_m7_2"});
      vecs.push_back('{OP_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, "rem_m7_2"});
      vecs.push_back('{OP_DIVU,   32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, "divu_big_2"});
      vecs.push_back('{OP_DIV,    32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFF, "div_by0"});
      vecs.push_back('{OP_REMU,   32'h1234_5678, 32'h0000_0000, 32'h1234_5678, "remu_by0"});
      vecs.push_back('{OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf"});
      vecs.push_back('{OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, "rem_ovf"});
      vecs.push_back('{OP_DIVU,   32'hDEAD_BEEF, 32'h0000_0000, 32'hFFFF_FFFF, "divu_by0"});
      vecs.push_back('{OP_REM,    32'hFFFF_FF00, 32'h0000_0000, 32'hFFFF_FF00, "rem_by0_neg"});
      vecs.push_back('{OP_MUL,    32'h0000_0000, 32'h0000_0005, 32'h0000_0000, "mul_zero"});
      vecs.push_back('{OP_REMU,   32'h0000_0005, 32'h0000_0007, 32'h0000_0005, "remu_small"});
      vecs.push_back('{OP_DIV,    32'hFFFF_FFFB, 32'h0000_0007, 32'h0000_0000, "div_small_neg"});
      vecs.push_back('{OP_REM,    32'hFFFF_FFFB, 32'h0000_0007, 32'hFFFF_FFFB, "rem_small_neg"});

      foreach (vecs[i])
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp,
                exp_lat(vecs[i].op, vecs[i].a, vecs[i].b), vecs[i].name);

      // start held high with new operands during CALC must be ignored
      wait_ready("hold_start");
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = OP_DIV;
      bus.data1 = 32'd100;
      bus.data2 = 32'd7;
      @(posedge clk); #1;
      bus.op    = OP_MUL;
      bus.data1 = $urandom;
      bus.data2 = $urandom;
      lat       = 0;
      for (int i = 1; i <= 100; i++) begin
         @(posedge clk); #1;
         if (i == 20) bus.start = 1'b0;
         if (bus.valid) begin
            lat = i;
            break;
         end
      end
      bus.start = 1'b0;
      chk("hold_start result", bus.Result, 32'd14);
      chk("hold_start latency", 32'(lat), 32'(W + 1));
      @(posedge clk); #1;
      chk("hold_start valid_once", 32'(bus.valid), 32'd0);

      // one-cycle reset in the middle of CALC aborts without a valid pulse
      run_op(OP_MUL, 32'd6, 32'd7, 32'd42, W + 1, "pre_rst");
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = OP_MUL;
      bus.data1 = 32'h0000_1234;
      bus.data2 = 32'h0000_5678;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("abort ready", 32'(bus.ready), 32'd1);
      chk("abort valid", 32'(bus.valid), 32'd0);
      chk("abort Result", bus.Result, 32'd0);
      @(negedge clk);
      rst    = 1'b0;
      vcount = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (bus.valid) vcount++;
      end
      chk("abort no_valid", 32'(vcount), 32'd0);
      run_op(OP_MUL, 32'd3, 32'd5, 32'h0000_000F, exp_lat(OP_MUL, 32'd3, 32'd5), "mul_after_rst");

      // randomized operations against the wide-arithmetic model
      for (int n = 0; n < 150; n++) begin
         rop = muldiv_op_e'(3'($urandom_range(0, 7)));
         ra  = $urandom;
         rb  = $urandom;
         case ($urandom_range(0, 7))
            0: rb = '0;
            1: rb = 32'($urandom_range(1, 15));
            2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            3: ra = '0;
            4: ra = 32'($urandom_range(0, 255));
            default: ;
         endcase
         run_op(rop, ra, rb, ref_model(rop, ra, rb), exp_lat(rop, ra, rb), "rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
